// File: rtl/mult_pkg.sv
// Shared encodings for the sequential multiplier: FSM states and counter sizing.
package mult_pkg;

    typedef enum logic [1:0] {
        REPOSO = 2'd0,
        SUMA   = 2'd1,
        SIGNO  = 2'd2,
        FIN    = 2'd3
    } estado_t;

    // Step counter width able to hold 0..n.
    function automatic int ancho_cnt(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/paso_suma_desplaza.sv
// One shift-and-add step: conditional N+1-bit add of mcand into acc, then shift
// {acc, mplier} right by one.
module paso_suma_desplaza #(
    parameter int N = 8
) (
    input  logic [N:0]   i_acc,
    input  logic [N-1:0] i_mplier,
    input  logic [N-1:0] i_mcand,
    output logic [N:0]   o_acc,
    output logic [N-1:0] o_mplier
);

    logic [N:0] w_suma;

    // acc[N] is always zero between steps, so the N+1-bit sum is {carry, sum}.
    always_comb begin
        w_suma = i_acc;
        if (i_mplier[0])
            w_suma = i_acc + {1'b0, i_mcand};
    end

    assign {o_acc, o_mplier} = {1'b0, w_suma, i_mplier[N-1:1]};

endmodule

// File: rtl/control_multiplicador.sv
// Sequential shift-and-add multiplier controller (fixed N+3 cycle operation).
// MULT_SIGNADO_EN: two's-complement operands; undefined builds are unsigned.
module control_multiplicador #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           inicio,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           listo,
    output logic           valido,
    output logic [2*N-1:0] producto
);
    import mult_pkg::*;

    localparam int CW = ancho_cnt(N);

    estado_t          r_estado;
    estado_t          w_sig;
    logic [N-1:0]     r_mcand;
    logic [N-1:0]     r_mplier;
    logic [N:0]       r_acc;
    logic             r_signo;
    logic [CW-1:0]    r_cnt;
    logic [2*N-1:0]   r_producto;

    logic [N-1:0]     w_mag_a;
    logic [N-1:0]     w_mag_b;
    logic             w_signo;
    logic [N:0]       w_acc_sig;
    logic [N-1:0]     w_mplier_sig;
    logic [2*N-1:0]   w_res;
    logic [2*N-1:0]   w_prod;

    always_comb begin
`ifdef MULT_SIGNADO_EN
        w_mag_a = a[N-1] ? (~a + 1'b1) : a;
        w_mag_b = b[N-1] ? (~b + 1'b1) : b;
        w_signo = a[N-1] ^ b[N-1];
`else
        w_mag_a = a;
        w_mag_b = b;
        w_signo = 1'b0;
`endif
    end

    paso_suma_desplaza #(.N(N)) u_paso (
        .i_acc    (r_acc),
        .i_mplier (r_mplier),
        .i_mcand  (r_mcand),
        .o_acc    (w_acc_sig),
        .o_mplier (w_mplier_sig)
    );

    // Negating zero yields zero, so no special case is needed here.
    assign w_res  = {r_acc[N-1:0], r_mplier};
    assign w_prod = r_signo ? (~w_res + 1'b1) : w_res;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_estado <= REPOSO;
        else
            r_estado <= w_sig;
    end

    always_comb begin
        w_sig = r_estado;
        case (r_estado)
            REPOSO: if (inicio) w_sig = SUMA;
            SUMA:   if (r_cnt == CW'(N - 1)) w_sig = SIGNO;
            SIGNO:  w_sig = FIN;
            FIN:    w_sig = REPOSO;
            default: w_sig = REPOSO;
        endcase
    end

    always_comb begin
        listo    = (r_estado == REPOSO);
        valido   = (r_estado == FIN);
        producto = r_producto;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_acc      <= '0;
            r_signo    <= 1'b0;
            r_cnt      <= '0;
            r_producto <= '0;
        end else begin
            case (r_estado)
                REPOSO: begin
                    if (inicio) begin
                        r_mcand  <= w_mag_a;
                        r_mplier <= w_mag_b;
                        r_signo  <= w_signo;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                    end
                end
                SUMA: begin
                    r_acc    <= w_acc_sig;
                    r_mplier <= w_mplier_sig;
                    r_cnt    <= r_cnt + 1'b1;
                end
                SIGNO: r_producto <= w_prod;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_multiplicador.sv
// Directed bench for control_multiplicador; expectations follow MULT_SIGNADO_EN.
module tb_control_multiplicador;
    localparam int N = 8;

`ifdef MULT_SIGNADO_EN
    localparam bit SG = 1'b1;
`else
    localparam bit SG = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           inicio = 1'b0;
    logic [N-1:0]   a = '0;
    logic [N-1:0]   b = '0;
    logic           listo;
    logic           valido;
    logic [2*N-1:0] producto;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    control_multiplicador #(.N(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .inicio   (inicio),
        .a        (a),
        .b        (b),
        .listo    (listo),
        .valido   (valido),
        .producto (producto)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] modelo(input logic [7:0] x, input logic [7:0] y);
        logic signed [15:0] ps;
        logic [15:0]        pu;
        ps = $signed(x) * $signed(y);
        pu = x * y;
        return SG ? 16'(ps) : pu;
    endfunction

    task automatic mul(input string tag, input logic [7:0] x, input logic [7:0] y,
                       input logic [15:0] exp);
        int k;
        @(negedge clk);
        a = x; b = y; inicio = 1'b1;
        chk({tag, ".listo_in"}, 32'(listo), 1);
        @(posedge clk); #1;
        inicio = 1'b0;
        a = ~x; b = ~y;
        chk({tag, ".ocupado"}, 32'(listo), 0);
        k = 0;
        while (!valido && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk({tag, ".lat"}, 32'(k), N + 1);
        chk({tag, ".prod"}, 32'(producto), 32'(exp));
        @(posedge clk); #1;
        chk({tag, ".pulso"}, 32'(valido), 0);
        chk({tag, ".listo_out"}, 32'(listo), 1);
        chk({tag, ".hold"}, 32'(producto), 32'(exp));
    endtask

    logic [7:0]  ta [5] = '{8'd7, 8'h80, 8'hFD, 8'd0, 8'd100};
    logic [7:0]  tb [5] = '{8'd6, 8'h7F, 8'd5, 8'hFF, 8'h9C};
    logic [15:0] q [$];

    initial begin
        int gap;
        int nres;
        int w;

        #2;
        chk("rst.listo", 32'(listo), 1);
        chk("rst.valido", 32'(valido), 0);
        chk("rst.prod", 32'(producto), 0);
        @(negedge clk);
        rst_n = 1'b1;

        mul("7x6",     8'd7,  8'd6,  16'h002A);
        mul("m128sq",  8'h80, 8'h80, 16'h4000);
        mul("m128x127", 8'h80, 8'h7F, SG ? 16'hC080 : 16'h3F80);
        mul("m3x5",    8'hFD, 8'h05, SG ? 16'hFFF1 : 16'h04F1);
        mul("0xff",    8'h00, 8'hFF, 16'h0000);
        mul("ffxff",   8'hFF, 8'hFF, SG ? 16'h0001 : 16'hFE01);

        // inicio held high with operands changing every cycle
        gap = -1;
        nres = 0;
        for (int c = 0; c < 46; c++) begin
            @(negedge clk);
            if (valido) begin
                chk("hh.cola", 32'(q.size() > 0), 1);
                if (q.size() > 0) chk("hh.res", 32'(producto), 32'(q.pop_front()));
                if (gap >= 0) chk("hh.gap", 32'(gap + 1 >= N + 2), 1);
                gap = 0;
                nres++;
            end else if (gap >= 0) begin
                gap++;
            end
            a = ta[c % 5];
            b = tb[(c + 2) % 5];
            inicio = (c < 45);
            if (listo && inicio) q.push_back(modelo(a, b));
        end
        w = 0;
        while (q.size() > 0 && w < 40) begin
            @(negedge clk);
            w++;
            if (valido) begin
                chk("hh.res", 32'(producto), 32'(q.pop_front()));
                nres++;
            end
        end
        chk("hh.vacia", 32'(q.size()), 0);
        chk("hh.nres", 32'(nres >= 4), 1);

        // reset in the middle of an operation
        @(negedge clk);
        a = 8'd5; b = 8'd7; inicio = 1'b1;
        @(posedge clk); #1;
        inicio = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        chk("mid.prod_prev", 32'(producto != 0), 1);
        rst_n = 1'b0;
        #1;
        chk("mid.listo", 32'(listo), 1);
        chk("mid.valido", 32'(valido), 0);
        chk("mid.prod", 32'(producto), 0);
        @(negedge clk);
        rst_n = 1'b1;
        mul("3x3", 8'd3, 8'd3, 16'h0009);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
